// File: rtl/red_pitaya_pwm_bank.sv
// red_pitaya_pwm_bank: bus-mapped bank of CHN PWM DACs, DW-bit duty, double-buffered duty registers.
// Defining PWM_BANK_SIGMA_DELTA_EN adds a first-order sigma-delta mode selected by CTRL.MODE.
module red_pitaya_pwm_bank #(
    parameter int unsigned CHN = 4,
    parameter int unsigned DW  = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [31:0]    sys_addr,
    input  logic [31:0]    sys_wdata,
    input  logic           sys_wen,
    input  logic           sys_ren,
    output logic [31:0]    sys_rdata,
    output logic           sys_err,
    output logic           sys_ack,
    output logic [CHN-1:0] pwm_o,
    output logic           cycle_o
);
    localparam logic [DW-1:0] CNT_LAST  = {{(DW-1){1'b1}}, 1'b0};
    localparam logic [7:0]    ADDR_CTRL = 8'h20;
    localparam logic [7:0]    ADDR_STAT = 8'h24;

    logic [DW-1:0]  shadow_q [CHN];
    logic [DW-1:0]  shadow_d [CHN];
    logic [DW-1:0]  active_q [CHN];
    logic [DW-1:0]  active_d [CHN];
    logic [DW-1:0]  cnt_q, cnt_d;
    logic           en_q, en_d;
    logic [CHN-1:0] pwm_q, pwm_d;
    logic           cycle_q, cycle_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           ack_q, ack_d;

    logic [7:0]     addr;
    logic [CHN-1:0] duty_sel;
    logic           mapped;
    logic [31:0]    rd_mux;
    logic           run, last, mode_cur, mode_nxt, mode_chg;
    logic           unused_bits;

`ifdef PWM_BANK_SIGMA_DELTA_EN
    logic           mode_q, mode_d;
    logic [DW:0]    acc_q [CHN];
    logic [DW:0]    acc_d [CHN];
    assign mode_cur = mode_q;
    assign mode_nxt = mode_d;
`else
    assign mode_cur = 1'b0;
    assign mode_nxt = 1'b0;
`endif

    assign addr        = sys_addr[7:0];
    assign unused_bits = ^{sys_addr[31:8], sys_wdata[31:DW]};

    always_comb begin
        duty_sel = '0;
        for (int unsigned n = 0; n < CHN; n++)
            duty_sel[n] = (addr[7:5] == 3'd0) && (addr[4:2] == 3'(n)) && (addr[1:0] == 2'd0);
    end

    assign mapped = (|duty_sel) || (addr == ADDR_CTRL) || (addr == ADDR_STAT);

    always_comb begin
        rd_mux = '0;
        if (addr == ADDR_CTRL)
            rd_mux[1:0] = {mode_cur, en_q};
        if (addr == ADDR_STAT) begin
            rd_mux[DW-1:0] = cnt_q;
            rd_mux[31]     = en_q;
        end
        for (int unsigned n = 0; n < CHN; n++)
            if (duty_sel[n])
                rd_mux[DW-1:0] = shadow_q[n];
    end

    // Write wins over a simultaneous read; unmapped accesses still ack, flag err and change nothing.
    always_comb begin
        ack_d    = sys_wen | sys_ren;
        err_d    = ack_d & ~mapped;
        rdata_d  = (sys_ren && !sys_wen) ? rd_mux : '0;
        en_d     = en_q;
        shadow_d = shadow_q;
        if (sys_wen && addr == ADDR_CTRL)
            en_d = sys_wdata[0];
        for (int unsigned n = 0; n < CHN; n++)
            if (sys_wen && duty_sel[n])
                shadow_d[n] = sys_wdata[DW-1:0];
`ifdef PWM_BANK_SIGMA_DELTA_EN
        mode_d = mode_q;
        if (sys_wen && addr == ADDR_CTRL)
            mode_d = sys_wdata[1];
`endif
    end

    assign run      = en_q & en_d;
    assign last     = (cnt_q == CNT_LAST);
    assign mode_chg = mode_nxt ^ mode_cur;

    // Outputs drop in the same edge that clears EN; a rising EN only reloads duties and parks cnt at 0.
    always_comb begin
        cnt_d    = '0;
        pwm_d    = '0;
        cycle_d  = 1'b0;
        active_d = active_q;
        if ((en_d && !en_q) || (run && last))
            active_d = shadow_q;
        if (run && !mode_chg) begin
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            cycle_d = (cnt_q == '0);
            for (int unsigned n = 0; n < CHN; n++) begin
`ifdef PWM_BANK_SIGMA_DELTA_EN
                pwm_d[n] = mode_q ? acc_q[n][DW] : (cnt_q < active_q[n]);
`else
                pwm_d[n] = (cnt_q < active_q[n]);
`endif
            end
        end
    end

`ifdef PWM_BANK_SIGMA_DELTA_EN
    always_comb begin
        acc_d = '{default: '0};
        for (int unsigned n = 0; n < CHN; n++)
            if (run && !mode_chg && mode_q)
                acc_d[n] = {1'b0, acc_q[n][DW-1:0]} + {1'b0, active_q[n]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= 1'b0;
            acc_q  <= '{default: '0};
        end else begin
            mode_q <= mode_d;
            acc_q  <= acc_d;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            cnt_q    <= '0;
            en_q     <= 1'b0;
            pwm_q    <= '0;
            cycle_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            pwm_q    <= pwm_d;
            cycle_q  <= cycle_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
        end
    end

    assign sys_rdata = rdata_q;
    assign sys_err   = err_q;
    assign sys_ack   = ack_q;
    assign pwm_o     = pwm_q;
    assign cycle_o   = cycle_q;
endmodule

// File: tb/tb_red_pitaya_pwm_bank.sv
// tb_red_pitaya_pwm_bank: randomized bus traffic checked through a response scoreboard, plus a
// per-cycle model of pwm_o/cycle_o derived from enable time, period length and the duty write log.
module tb_red_pitaya_pwm_bank;
    localparam int CHN   = 4;
    localparam int DW    = 8;
    localparam int P     = (1 << DW) - 1;
    localparam int NEVER = 32'h7fff_ffff;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [31:0]    sys_addr = '0;
    logic [31:0]    sys_wdata = '0;
    logic           sys_wen = 1'b0;
    logic           sys_ren = 1'b0;
    logic [31:0]    sys_rdata;
    logic           sys_err;
    logic           sys_ack;
    logic [CHN-1:0] pwm_o;
    logic           cycle_o;

    red_pitaya_pwm_bank #(.CHN(CHN), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
        .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata), .sys_err(sys_err),
        .sys_ack(sys_ack), .pwm_o(pwm_o), .cycle_o(cycle_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;  // number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int e; int ch; int val; } wr_t;
    typedef struct { int due; bit chk; logic [31:0] rdata; bit err; } exp_t;

    wr_t  wr_log[$];
    exp_t sb[$];
    int   t_en  = -1;
    int   t_dis = NEVER;
    bit   m_en  = 1'b0;
    bit   m_mode = 1'b0;
    int   tests = 0;
    int   fails = 0;

    // Shadow value of channel ch as written strictly before edge e.
    function automatic int duty_at(input int ch, input int e);
        int v = 0;
        foreach (wr_log[i])
            if (wr_log[i].ch == ch && wr_log[i].e < e) v = wr_log[i].val;
        return v;
    endfunction

    // Expected {cycle_o, pwm_o} after edge t: period k starts at edge t_en+1+P*k and uses the
    // shadow captured at edge t_en+P*k.
    function automatic logic [CHN:0] exp_out(input int t);
        logic [CHN:0] r = '0;
        int c, k, ph;
        if (t_en < 0 || t < t_en + 1 || t >= t_dis) return r;
        c  = t - t_en - 1;
        k  = c / P;
        ph = c % P;
        r[CHN] = (ph == 0);
        for (int n = 0; n < CHN; n++) r[n] = (ph < duty_at(n, t_en + P * k));
        return r;
    endfunction

    task automatic bus(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        int   e, a8;
        bit   is_duty, is_ctrl, is_stat;
        e       = cyc + 1;
        a8      = int'(a[7:0]);
        is_duty = (a8 < 4 * CHN) && (a8 % 4 == 0);
        is_ctrl = (a8 == 32);
        is_stat = (a8 == 36);
        x.due   = e;
        x.chk   = !wr;
        x.rdata = '0;
        x.err   = !(is_duty || is_ctrl || is_stat);
        if (wr) begin
            if (is_duty) wr_log.push_back('{e, a8 / 4, int'(d[DW-1:0])});
            if (is_ctrl) begin
                if (d[0] && !m_en) begin t_en = e; t_dis = NEVER; end
                if (!d[0] && m_en) t_dis = e;
                m_en = d[0];
`ifdef PWM_BANK_SIGMA_DELTA_EN
                m_mode = d[1];
`endif
            end
        end else if (is_duty) x.rdata = 32'(duty_at(a8 / 4, e));
        else if (is_ctrl) x.rdata = {30'd0, m_mode, m_en};
        else if (is_stat && m_en) x.rdata = 32'h8000_0000 | 32'((e - 1 - t_en) % P);
        sb.push_back(x);
        sys_addr  = a;
        sys_wdata = d;
        sys_wen   = wr;
        sys_ren   = rd;
        @(negedge clk);
        sys_wen = 1'b0;
        sys_ren = 1'b0;
    endtask

    task automatic at_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({sys_rdata, sys_err, sys_ack, pwm_o, cycle_o} !== '0) begin
            fails++;
            $display("FAIL %s got rdata=%h err=%b ack=%b pwm=%b cycle=%b exp all 0",
                     name, sys_rdata, sys_err, sys_ack, pwm_o, cycle_o);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [CHN:0] ex;
        exp_t x;
        if (!rst) begin
            ex = exp_out(cyc);
            tests++;
            if ({cycle_o, pwm_o} !== ex) begin
                fails++;
                $display("FAIL pwm cyc=%0d got {cycle,pwm}=%b exp=%b", cyc, {cycle_o, pwm_o}, ex);
            end
            if (sb.size() != 0 && sb[0].due == cyc) begin
                x = sb.pop_front();
                tests++;
                if (sys_ack !== 1'b1 || sys_err !== x.err || (x.chk && sys_rdata !== x.rdata)) begin
                    fails++;
                    $display("FAIL bus_resp cyc=%0d got ack=%b err=%b rdata=%h exp ack=1 err=%b rdata=%h",
                             cyc, sys_ack, sys_err, sys_rdata, x.err, x.chk ? x.rdata : sys_rdata);
                end
            end else begin
                tests++;
                if (sys_ack !== 1'b0) begin
                    fails++;
                    $display("FAIL bus_idle cyc=%0d got ack=%b exp ack=0", cyc, sys_ack);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog got no finish exp finish before 2ms");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, op, w, ch;
        #2 rst = 1'b1;
        #1 check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        bus(0, 1, 32'h20, 0);
        bus(0, 1, 32'h24, 0);
        bus(0, 1, 32'h00, 0);
        bus(0, 1, 32'h30, 0);
        bus(1, 0, 32'h00, 64);
        bus(1, 0, 32'h04, 0);
        bus(1, 0, 32'h08, 255);
        bus(1, 0, 32'h0C, $urandom_range(0, 255));
        bus(1, 0, 32'h10, 32'h5A);
        bus(0, 1, 32'h10, 0);
`ifdef PWM_BANK_SIGMA_DELTA_EN
        bus(1, 0, 32'h20, 1);
`else
        bus(1, 0, 32'h20, 3);
`endif
        bus(0, 1, 32'h20, 0);
        bus(0, 1, 32'h00, 0);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(20, 120)) @(negedge clk);
            bus(0, 1, 32'h24, 0);
        end

        k = (cyc - t_en) / P + 1;
        at_edge(t_en + 1 + 100 + P * k);
        bus(1, 0, 32'h00, 200);
        at_edge(t_en + 1 + 100 + P * (k + 1));
        bus(1, 0, 32'h00, 64);
        at_edge(t_en + P * (k + 3));
        bus(1, 0, 32'h00, 200);
        at_edge(t_en + P * (k + 5));

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 4);
            w  = $urandom_range(0, 90);
            ch = $urandom_range(0, 7);
            repeat (w) @(negedge clk);
            case (op)
                0, 1: bus(1, 0, {24'($urandom), 8'(ch * 4)}, $urandom);
                2:    bus(0, 1, {24'($urandom), 8'(ch * 4)}, 0);
                3:    bus(0, 1, {24'($urandom), 8'($urandom_range(0, 255))}, 0);
                default: bus(1, 1, {24'($urandom), 8'(ch * 4)}, $urandom);
            endcase
        end

        bus(1, 0, 32'h20, 0);
        repeat (50) @(negedge clk);
        bus(0, 1, 32'h24, 0);
        bus(0, 1, 32'h04, 0);
        bus(0, 1, 32'h08, 0);
        bus(1, 0, 32'h20, 1);
        repeat (2 * P + 30) @(negedge clk);

        sys_addr = 32'h20;
        sys_ren  = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        sys_ren = 1'b0;
        sb.delete();
        wr_log.delete();
        t_en   = -1;
        t_dis  = NEVER;
        m_en   = 1'b0;
        m_mode = 1'b0;
        #1 check_all_zero("reset_mid_period");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        bus(0, 1, 32'h20, 0);
        bus(0, 1, 32'h00, 0);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/red_pitaya_pwm_bank.md
RED_PITAYA_PWM_BANK -- requirements
Module: red_pitaya_pwm_bank

Interface
REQ-001 SHALL have parameter CHN, default 4: number of PWM DAC channels, legal range 1..8.
REQ-002 SHALL have parameter DW, default 8: duty resolution in bits, legal range 4..16.
REQ-003 SHALL have port clk_i, input, 1: single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port sys_addr, input, 32: bus address; only bits [7:0] are decoded.
REQ-006 SHALL have port sys_wdata, input, 32: bus write data.
REQ-007 SHALL have port sys_wen, input, 1: one-cycle write strobe.
REQ-008 SHALL have port sys_ren, input, 1: one-cycle read strobe.
REQ-009 SHALL have port sys_rdata, output, 32: registered read data.
REQ-010 SHALL have port sys_err, output, 1: error flag, valid with sys_ack.
REQ-011 SHALL have port sys_ack, output, 1: one-cycle access acknowledge.
REQ-012 SHALL have port pwm_o, output, CHN: per-channel PWM bitstream.
REQ-013 SHALL have port cycle_o, output, 1: one-cycle pulse at the first cycle of each period.

Function
REQ-014 Register map:
- 0x00+4*n: duty shadow for channel n (n<CHN), DW bits, zero-extended on read.
- 0x20: CTRL. Bit0 = EN; bit1 = MODE (0 PWM, 1 sigma-delta).
- 0x24: STAT. Bits [DW-1:0] = period counter; bit31 = EN.
REQ-015 Bus handshake:
- sys_ack SHALL assert exactly 1 cycle after sys_wen or sys_ren.
- sys_rdata SHALL be valid in the same cycle as sys_ack.
- If sys_wen and sys_ren assert in the same cycle, only the write SHALL be performed, with one ack.
REQ-016 An access to an unmapped address, including a duty address with n>=CHN, SHALL:
- assert sys_err with sys_ack;
- return 0 on read;
- discard a write.
REQ-017 Period counter cnt SHALL run 0..2^DW-2 and wrap to 0, giving a period of 2^DW-1 cycles. It advances only while EN=1.
REQ-018 The active duty SHALL load from the shadow on the last cycle of the period (cnt=2^DW-2), so it takes effect at cnt=0.
- A write in that same cycle SHALL take effect in the following period.
- Mid-period writes SHALL NOT change the current period.
REQ-019 PWM mode: pwm_o[n] SHALL be registered, with 1-cycle latency, as (cnt < active_duty[n]).
- duty=0 SHALL give constant low.
- duty=2^DW-1 SHALL give constant high.
REQ-020 cycle_o SHALL pulse for 1 cycle, aligned with pwm_o, for each period start while EN=1.
REQ-021 EN 1->0:
- pwm_o and cycle_o SHALL be 0 from the next cycle.
- cnt SHALL clear to 0.
- The shadow registers SHALL be kept.
REQ-022 EN 0->1: in the cycle after the write, the active duties SHALL load from the shadow and cnt SHALL start at 0.
REQ-023 A MODE change SHALL clear the counter and the accumulators, and SHALL take effect at the next cycle.

Reset
REQ-024 While rst_i=1 (asynchronous), the following SHALL all be 0:
- sys_rdata, sys_err, sys_ack, pwm_o, cycle_o;
- cnt, shadow and active duties, CTRL, sigma-delta accumulators.
REQ-025 Reset asserted mid-period or mid-access SHALL abort the operation; no ack SHALL be issued for an access in flight.
REQ-026 After rst_i deasserts, the first accepted strobe SHALL be the one sampled on the first rising edge with rst_i=0.

Configuration
REQ-027 With macro PWM_BANK_SIGMA_DELTA_EN defined, MODE=1 SHALL select first-order sigma-delta per channel.
- Each channel has a (DW+1)-bit accumulator: acc <= acc[DW-1:0] + active_duty.
- pwm_o[n] SHALL be registered from the carry acc[DW].
- Duty reload and cycle_o SHALL behave as in REQ-018 and REQ-020.
REQ-028 Without PWM_BANK_SIGMA_DELTA_EN:
- no accumulators SHALL be synthesised;
- CTRL bit1 SHALL read 0 and writes to it SHALL be ignored;
- the block SHALL be PWM-only.

Verification (CHN=4, DW=8, period 255 cycles)
REQ-029 Write 0x00=64, 0x20=1 -> from cycle_o onward, pwm_o[0] is high for 64 cycles and low for 191, repeating; cycle_o has a period of 255 cycles.
REQ-030 Write duty 0 and 255 to ch1/ch2 -> pwm_o[1] is constantly 0 and pwm_o[2] is constantly 1 across 3 periods.
REQ-031 Mid-period write ch0 64->200 at cnt=100 -> the current period keeps 64 high cycles; the next period has 200 high cycles. The same write at cnt=254 -> the next period still has 64 high cycles.
REQ-032 Read 0x30 -> sys_ack and sys_err are 1 one cycle later, and sys_rdata=0. Write 0x10 -> sys_err=1 and readback is 0.
REQ-033 With the macro: MODE=1, EN=1, duty=128 -> pwm_o[0] alternates 0/1. Over 256 cycles, duty=64 gives exactly 64 ones. Without the macro, CTRL reads back 0x1.
REQ-034 Pulse rst_i for 1 cycle mid-period -> all outputs are 0 at once, no pending ack, and CTRL reads 0 afterwards.
